// File: rtl/branch_pc_unit.sv
// Fetch PC sequencer: sequential fetch, taken-branch/jump redirects with a
// fixed-length IF/ID flush window, and a sticky trap on misaligned targets.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Stall,
  input  logic        ExValid,
  input  logic        Branch,
  input  logic [2:0]  jump,
  input  logic        Zero,
  input  logic [31:0] AluResult,
  input  logic [31:0] ExPC,
  input  logic [31:0] Imm,
  output logic [31:0] PC,
  output logic        FetchValid,
  output logic        Flush,
  output logic        MisalignErr,
  output logic [15:0] RedirectCnt
);

  localparam logic [2:0] JUMP_JALR  = 3'd7;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;

  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_seq;

  always_comb begin
    taken  = ExValid & Branch & Zero;
    // jalr supplies a word address, so it is scaled back to bytes.
    target = (jump == JUMP_JALR) ? (AluResult << 2) : (ExPC + Imm);
    pc_seq = Stall ? pc_q : (pc_q + 32'd4);
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    fetch_valid_d  = fetch_valid_q;
    flush_d        = flush_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    case (state_q)
      IDLE: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (taken && target[1:0] == 2'b00) begin
          pc_d        = target;
          state_d     = FLUSH;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_INIT;
          if (redirect_cnt_q != 16'hFFFF)
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end else if (taken) begin
          state_d       = TRAP;
          misalign_d    = 1'b1;
          fetch_valid_d = 1'b0;
        end else begin
          pc_d = pc_seq;
        end
      end
      FLUSH: begin
        pc_d = pc_seq;
        if (flush_cnt_q == 3'd0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      TRAP: begin
        fetch_valid_d = 1'b0;
        misalign_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      fetch_valid_q  <= 1'b0;
      flush_q        <= 1'b0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= 16'd0;
      flush_cnt_q    <= 3'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_valid_q  <= fetch_valid_d;
      flush_q        <= flush_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign PC          = pc_q;
  assign FetchValid  = fetch_valid_q;
  assign Flush       = flush_q;
  assign MisalignErr = misalign_q;
  assign RedirectCnt = redirect_cnt_q;

endmodule
